// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command decoder: command codes, decoder
// states and the RGB565 pixel type.
package lcd_pkg;

    localparam logic [7:0] CMD_NOP     = 8'h00;
    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    typedef enum logic [2:0] {
        IDLE,
        CASET_P,
        PASET_P,
        RAM_LO,
        RAM_HI
    } lcd_dec_state_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // Colour arrives low byte first, high byte second.
    function automatic rgb565_t make_rgb565(input logic [7:0] hi, input logic [7:0] lo);
        return rgb565_t'({hi, lo});
    endfunction

endpackage

// File: rtl/lcd_addr_ptr.sv
// Column/page address window and the running pixel pointer that sweeps it
// left-to-right, top-to-bottom with wrap at both window edges.
module lcd_addr_ptr #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        win_full_i,
    input  logic        col_wr_i,
    input  logic        page_wr_i,
    input  logic [15:0] start_i,
    input  logic [15:0] end_i,
    input  logic        ptr_load_i,
    input  logic        ptr_adv_i,
    output logic [15:0] x_o,
    output logic [15:0] y_o
);

    localparam logic [15:0] EC_FULL = 16'(WIDTH - 1);
    localparam logic [15:0] EP_FULL = 16'(HEIGHT - 1);

    logic [15:0] sc_q, sc_d;
    logic [15:0] ec_q, ec_d;
    logic [15:0] sp_q, sp_d;
    logic [15:0] ep_q, ep_d;
    logic [15:0] x_q,  x_d;
    logic [15:0] y_q,  y_d;

    always_comb begin
        sc_d = sc_q;
        ec_d = ec_q;
        sp_d = sp_q;
        ep_d = ep_q;
        if (win_full_i) begin
            sc_d = 16'd0;
            ec_d = EC_FULL;
            sp_d = 16'd0;
            ep_d = EP_FULL;
        end else begin
            if (col_wr_i) begin
                sc_d = start_i;
                ec_d = end_i;
            end
            if (page_wr_i) begin
                sp_d = start_i;
                ep_d = end_i;
            end
        end
    end

    // Comparisons use >= so a pointer left outside a shrunken window still wraps.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (ptr_load_i) begin
            x_d = sc_q;
            y_d = sp_q;
        end else if (ptr_adv_i) begin
            if (x_q >= ec_q) begin
                x_d = sc_q;
                if (y_q >= ep_q) begin
                    y_d = sp_q;
                end else begin
                    y_d = y_q + 16'd1;
                end
            end else begin
                x_d = x_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sc_q <= 16'd0;
            ec_q <= EC_FULL;
            sp_q <= 16'd0;
            ep_q <= EP_FULL;
            x_q  <= 16'd0;
            y_q  <= 16'd0;
        end else begin
            sc_q <= sc_d;
            ec_q <= ec_d;
            sp_q <= sp_d;
            ep_q <= ep_d;
            x_q  <= x_d;
            y_q  <= y_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;

endmodule

// File: rtl/lcd_cmd_decoder.sv
// Receive-side decoder for the LCD command/data byte stream: parses commands,
// maintains the address window and emits addressed RGB565 pixel writes.
module lcd_cmd_decoder
    import lcd_pkg::*;
#(
    parameter int WIDTH       = 320,
    parameter int HEIGHT      = 240,
    parameter int WAIT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [7:0]  D,
    input  logic        dcx,
    output logic        px_valid,
    output logic [15:0] px_x,
    output logic [15:0] px_y,
    output logic [15:0] px_color,
    output logic        disp_on,
    output logic        sleeping,
    output logic        cmd_err
);

    localparam logic [31:0] WAIT_LOAD = 32'(WAIT_CYCLES);
    localparam logic [15:0] COL_LIMIT = 16'(WIDTH);
    localparam logic [15:0] ROW_LIMIT = 16'(HEIGHT);

    lcd_dec_state_t state_q, state_d;
    logic [1:0]     idx_q, idx_d;
    logic [7:0]     p0_q, p0_d;
    logic [7:0]     p1_q, p1_d;
    logic [7:0]     p2_q, p2_d;
    logic [7:0]     lo_q, lo_d;
    logic [31:0]    wait_q, wait_d;

    logic           px_valid_q, px_valid_d;
    logic [15:0]    px_x_q, px_x_d;
    logic [15:0]    px_y_q, px_y_d;
    rgb565_t        px_color_q, px_color_d;
    logic           disp_on_q, disp_on_d;
    logic           sleeping_q, sleeping_d;
    logic           cmd_err_q, cmd_err_d;

    logic           win_full;
    logic           col_wr;
    logic           page_wr;
    logic           ptr_load;
    logic           ptr_adv;
    logic [15:0]    win_start;
    logic [15:0]    win_end;
    logic [15:0]    win_limit;
    logic [15:0]    cur_x;
    logic [15:0]    cur_y;

    assign win_start = {p0_q, p1_q};
    assign win_end   = {p2_q, D};
    assign win_limit = (state_q == CASET_P) ? COL_LIMIT : ROW_LIMIT;

    lcd_addr_ptr #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT)
    ) u_addr_ptr (
        .clk_i     (clk),
        .rst_i     (rst),
        .win_full_i(win_full),
        .col_wr_i  (col_wr),
        .page_wr_i (page_wr),
        .start_i   (win_start),
        .end_i     (win_end),
        .ptr_load_i(ptr_load),
        .ptr_adv_i (ptr_adv),
        .x_o       (cur_x),
        .y_o       (cur_y)
    );

    // Any byte during the quiet period is rejected before decoding.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        p0_d       = p0_q;
        p1_d       = p1_q;
        p2_d       = p2_q;
        lo_d       = lo_q;
        wait_d     = (wait_q != 32'd0) ? wait_q - 32'd1 : 32'd0;
        px_valid_d = 1'b0;
        px_x_d     = px_x_q;
        px_y_d     = px_y_q;
        px_color_d = px_color_q;
        disp_on_d  = disp_on_q;
        sleeping_d = sleeping_q;
        cmd_err_d  = 1'b0;
        win_full   = 1'b0;
        col_wr     = 1'b0;
        page_wr    = 1'b0;
        ptr_load   = 1'b0;
        ptr_adv    = 1'b0;

        if (wr_en) begin
            if (wait_q != 32'd0) begin
                cmd_err_d = 1'b1;
            end else if (!dcx) begin
                state_d = IDLE;
                case (D)
                    CMD_NOP: ;
                    CMD_SWRESET: begin
                        win_full   = 1'b1;
                        disp_on_d  = 1'b0;
                        sleeping_d = 1'b1;
                        wait_d     = WAIT_LOAD;
                    end
                    CMD_SLPOUT: begin
                        sleeping_d = 1'b0;
                        wait_d     = WAIT_LOAD;
                    end
                    CMD_DISPOFF: disp_on_d = 1'b0;
                    CMD_DISPON:  disp_on_d = 1'b1;
                    CMD_CASET: begin
                        state_d = CASET_P;
                        idx_d   = 2'd0;
                    end
                    CMD_PASET: begin
                        state_d = PASET_P;
                        idx_d   = 2'd0;
                    end
                    CMD_RAMWR: begin
                        state_d  = RAM_LO;
                        ptr_load = 1'b1;
                    end
                    default: cmd_err_d = 1'b1;
                endcase
            end else begin
                case (state_q)
                    CASET_P, PASET_P: begin
                        idx_d = idx_q + 2'd1;
                        case (idx_q)
                            2'd0: p0_d = D;
                            2'd1: p1_d = D;
                            2'd2: p2_d = D;
                            default: begin
                                state_d = IDLE;
                                if ((win_start <= win_end) && (win_end < win_limit)) begin
                                    col_wr  = (state_q == CASET_P);
                                    page_wr = (state_q == PASET_P);
                                end else begin
                                    cmd_err_d = 1'b1;
                                end
                            end
                        endcase
                    end
                    RAM_LO: begin
                        lo_d    = D;
                        state_d = RAM_HI;
                    end
                    RAM_HI: begin
                        px_valid_d = 1'b1;
                        px_x_d     = cur_x;
                        px_y_d     = cur_y;
                        px_color_d = make_rgb565(D, lo_q);
                        ptr_adv    = 1'b1;
                        state_d    = RAM_LO;
                    end
                    default: cmd_err_d = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            p0_q       <= 8'd0;
            p1_q       <= 8'd0;
            p2_q       <= 8'd0;
            lo_q       <= 8'd0;
            wait_q     <= 32'd0;
            px_valid_q <= 1'b0;
            px_x_q     <= 16'd0;
            px_y_q     <= 16'd0;
            px_color_q <= '0;
            disp_on_q  <= 1'b0;
            sleeping_q <= 1'b1;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            p0_q       <= p0_d;
            p1_q       <= p1_d;
            p2_q       <= p2_d;
            lo_q       <= lo_d;
            wait_q     <= wait_d;
            px_valid_q <= px_valid_d;
            px_x_q     <= px_x_d;
            px_y_q     <= px_y_d;
            px_color_q <= px_color_d;
            disp_on_q  <= disp_on_d;
            sleeping_q <= sleeping_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    assign px_valid = px_valid_q;
    assign px_x     = px_x_q;
    assign px_y     = px_y_q;
    assign px_color = px_color_q;
    assign disp_on  = disp_on_q;
    assign sleeping = sleeping_q;
    assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_lcd_cmd_decoder.sv
// Directed bench for lcd_cmd_decoder: expected pixels are queued as colour
// bytes are sent and popped when the decoder reports a pixel write.
module tb_lcd_cmd_decoder;
    import lcd_pkg::*;

    localparam int W    = 320;
    localparam int H    = 240;
    localparam int WAIT = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [7:0]  D;
    logic        dcx;
    logic        px_valid;
    logic [15:0] px_x;
    logic [15:0] px_y;
    logic [15:0] px_color;
    logic        disp_on;
    logic        sleeping;
    logic        cmd_err;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] c;
    } pix_t;

    pix_t expQ[$];
    int   checkCount = 0;
    int   passCount  = 0;
    int   failCount  = 0;
    int   errCount   = 0;
    int   pixCount   = 0;
    int   e0;
    int   p0;

    always #5 clk = ~clk;

    lcd_cmd_decoder #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .WAIT_CYCLES(WAIT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .D       (D),
        .dcx     (dcx),
        .px_valid(px_valid),
        .px_x    (px_x),
        .px_y    (px_y),
        .px_color(px_color),
        .disp_on (disp_on),
        .sleeping(sleeping),
        .cmd_err (cmd_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one byte for exactly one accepting edge; returns at negedge+1.
    task automatic applyStimulus(input logic c, input logic [7:0] d);
        wr_en = 1'b1;
        dcx   = c;
        D     = d;
        @(negedge clk);
        #1;
        wr_en = 1'b0;
        dcx   = 1'b0;
        D     = 8'h00;
    endtask

    task automatic sendCmd(input logic [7:0] d);
        applyStimulus(1'b0, d);
    endtask

    task automatic sendData(input logic [7:0] d);
        applyStimulus(1'b1, d);
    endtask

    task automatic sendWindow(input logic [7:0] cmd, input logic [15:0] s, input logic [15:0] e);
        sendCmd(cmd);
        sendData(s[15:8]);
        sendData(s[7:0]);
        sendData(e[15:8]);
        sendData(e[7:0]);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pushPix(input int x, input int y, input logic [15:0] c);
        pix_t p;
        p.x = 16'(x);
        p.y = 16'(y);
        p.c = c;
        expQ.push_back(p);
    endtask

    task automatic checkResetState();
        checkOutput("rst_px_valid", {31'd0, px_valid}, 32'd0);
        checkOutput("rst_px_x", {16'd0, px_x}, 32'd0);
        checkOutput("rst_px_y", {16'd0, px_y}, 32'd0);
        checkOutput("rst_px_color", {16'd0, px_color}, 32'd0);
        checkOutput("rst_disp_on", {31'd0, disp_on}, 32'd0);
        checkOutput("rst_sleeping", {31'd0, sleeping}, 32'd1);
        checkOutput("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
    endtask

    // Pixel scoreboard and error-pulse counter, sampled away from the active edge.
    always @(negedge clk) begin : monitor
        pix_t e;
        if (!rst) begin
            if (cmd_err) errCount++;
            if (px_valid) begin
                pixCount++;
                checkCount++;
                assert (expQ.size() != 0) passCount++;
                else begin
                    failCount++;
                    $error("[TB] FAIL px_unexpected: got pixel (%0d,%0d)=0x%0h expected none", px_x, px_y, px_color);
                end
                if (expQ.size() != 0) begin
                    e = expQ.pop_front();
                    checkOutput("px_x", {16'd0, px_x}, {16'd0, e.x});
                    checkOutput("px_y", {16'd0, px_y}, {16'd0, e.y});
                    checkOutput("px_color", {16'd0, px_color}, {16'd0, e.c});
                end
            end
        end
    end

    initial begin
        rst   = 1'b1;
        wr_en = 1'b0;
        dcx   = 1'b0;
        D     = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        checkResetState();
        rst = 1'b0;
        idleCycles(1);

        $display("[TB] power-up commands and quiet period");
        sendCmd(CMD_DISPON);
        checkOutput("dispon", {31'd0, disp_on}, 32'd1);
        checkOutput("still_sleeping", {31'd0, sleeping}, 32'd1);
        sendCmd(CMD_SLPOUT);
        checkOutput("slpout", {31'd0, sleeping}, 32'd0);
        idleCycles(9);
        sendCmd(CMD_DISPOFF);
        checkOutput("wait_err", {31'd0, cmd_err}, 32'd1);
        checkOutput("wait_drop", {31'd0, disp_on}, 32'd1);
        idleCycles(1);
        checkOutput("err_one_cycle", {31'd0, cmd_err}, 32'd0);
        idleCycles(8);
        sendCmd(CMD_DISPOFF);
        checkOutput("wait_last_err", {31'd0, cmd_err}, 32'd1);
        checkOutput("wait_last_drop", {31'd0, disp_on}, 32'd1);
        sendCmd(CMD_DISPOFF);
        checkOutput("wait_over_ok", {31'd0, cmd_err}, 32'd0);
        checkOutput("dispoff", {31'd0, disp_on}, 32'd0);
        sendCmd(CMD_DISPON);
        checkOutput("dispon2", {31'd0, disp_on}, 32'd1);

        $display("[TB] 21x21 window sweep");
        e0 = errCount;
        p0 = pixCount;
        sendWindow(CMD_CASET, 16'd20, 16'd40);
        sendWindow(CMD_PASET, 16'd40, 16'd60);
        sendCmd(CMD_RAMWR);
        for (int y = 40; y <= 60; y++)
            for (int x = 20; x <= 40; x++)
                pushPix(x, y, 16'hF800);
        pushPix(20, 40, 16'hF800);
        repeat (442) begin
            sendData(8'h00);
            sendData(8'hF8);
        end
        idleCycles(2);
        checkOutput("sweep_drained", expQ.size(), 32'd0);
        checkOutput("sweep_count", pixCount - p0, 32'd442);
        checkOutput("sweep_no_err", errCount - e0, 32'd0);

        $display("[TB] rejected window");
        sendWindow(CMD_CASET, 16'd50, 16'd10);
        checkOutput("caset_bad_err", {31'd0, cmd_err}, 32'd1);
        sendCmd(CMD_RAMWR);
        checkOutput("caset_bad_pulse", {31'd0, cmd_err}, 32'd0);
        pushPix(20, 40, 16'h1234);
        sendData(8'h34);
        sendData(8'h12);
        idleCycles(1);
        checkOutput("caset_bad_drained", expQ.size(), 32'd0);

        $display("[TB] interrupted CASET");
        e0 = errCount;
        sendCmd(CMD_CASET);
        sendData(8'h00);
        sendData(8'h05);
        sendCmd(CMD_DISPOFF);
        checkOutput("cut_dispoff", {31'd0, disp_on}, 32'd0);
        sendCmd(CMD_RAMWR);
        pushPix(20, 40, 16'h0BAD);
        sendData(8'hAD);
        sendData(8'h0B);
        idleCycles(1);
        checkOutput("cut_no_err", errCount - e0, 32'd0);
        checkOutput("cut_drained", expQ.size(), 32'd0);
        sendCmd(CMD_DISPON);

        $display("[TB] abandoned low byte");
        p0 = pixCount;
        sendCmd(CMD_RAMWR);
        sendData(8'hAA);
        sendCmd(CMD_NOP);
        sendCmd(CMD_RAMWR);
        pushPix(20, 40, 16'h901E);
        sendData(8'h1E);
        sendData(8'h90);
        idleCycles(2);
        checkOutput("abandon_count", pixCount - p0, 32'd1);
        checkOutput("abandon_drained", expQ.size(), 32'd0);

        $display("[TB] protocol errors");
        sendCmd(CMD_NOP);
        sendData(8'h77);
        checkOutput("idle_data_err", {31'd0, cmd_err}, 32'd1);
        idleCycles(1);
        checkOutput("idle_data_pulse", {31'd0, cmd_err}, 32'd0);
        sendCmd(8'h55);
        checkOutput("unknown_cmd_err", {31'd0, cmd_err}, 32'd1);
        sendData(8'h01);
        checkOutput("unknown_to_idle", {31'd0, cmd_err}, 32'd1);

        $display("[TB] software reset");
        sendCmd(CMD_SWRESET);
        checkOutput("swreset_disp", {31'd0, disp_on}, 32'd0);
        checkOutput("swreset_sleep", {31'd0, sleeping}, 32'd1);
        idleCycles(WAIT);
        sendCmd(CMD_RAMWR);
        checkOutput("swreset_wait_done", {31'd0, cmd_err}, 32'd0);
        pushPix(0, 0, 16'hABCD);
        sendData(8'hCD);
        sendData(8'hAB);
        idleCycles(1);
        checkOutput("swreset_drained", expQ.size(), 32'd0);

        $display("[TB] window limits and single-row wrap");
        sendWindow(CMD_CASET, 16'd0, 16'd320);
        checkOutput("caset_limit_err", {31'd0, cmd_err}, 32'd1);
        sendWindow(CMD_PASET, 16'd0, 16'd240);
        checkOutput("paset_limit_err", {31'd0, cmd_err}, 32'd1);
        sendWindow(CMD_CASET, 16'd261, 16'd319);
        checkOutput("caset_edge_ok", {31'd0, cmd_err}, 32'd0);
        sendWindow(CMD_PASET, 16'd239, 16'd239);
        checkOutput("paset_edge_ok", {31'd0, cmd_err}, 32'd0);
        sendCmd(CMD_RAMWR);
        for (int i = 0; i < 60; i++) begin
            pushPix(261 + (i % 59), 239, 16'(i * 257));
            sendData(8'(i));
            sendData(8'(i));
        end
        idleCycles(1);
        checkOutput("edge_drained", expQ.size(), 32'd0);

        $display("[TB] reset during RAMWR");
        sendCmd(CMD_DISPON);
        sendCmd(CMD_RAMWR);
        pushPix(261, 239, 16'h5555);
        sendData(8'h55);
        sendData(8'h55);
        sendData(8'h11);
        #2;
        rst = 1'b1;
        #1;
        checkResetState();
        #1;
        rst = 1'b0;
        idleCycles(1);
        checkOutput("rst_drained", expQ.size(), 32'd0);
        sendData(8'h22);
        checkOutput("rst_pending_lost", {31'd0, cmd_err}, 32'd1);
        checkOutput("rst_no_pixel", {31'd0, px_valid}, 32'd0);
        idleCycles(2);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/lcd_cmd_decoder.md
# lcd_cmd_decoder

Receive-side decoder for the 8-bit LCD command/data byte stream (D, dcx) that the display command generator emits. Parses ILI9341-style commands (SWRESET, SLPOUT, DISPOFF, DISPON, CASET, PASET, RAMWR, NOP), tracks the column/page address window, and emits one addressed 16-bit pixel write per received colour pair. Used as a framebuffer-side display model and as the checking end of the command path in system benches.

## Interface
- WIDTH, 320: columns; legal column addresses 0..WIDTH-1
- HEIGHT, 240: rows; legal page addresses 0..HEIGHT-1
- WAIT_CYCLES, 50000: mandatory quiet period after SWRESET/SLPOUT

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  byte strobe; one byte accepted per cycle while high
- D  in  8  command or parameter byte
- dcx  in  1  0 = command, 1 = data/parameter
- px_valid  out  1  one-cycle pixel write pulse
- px_x  out  16  pixel column
- px_y  out  16  pixel row
- px_color  out  16  RGB565 colour
- disp_on  out  1  display enabled
- sleeping  out  1  panel in sleep
- cmd_err  out  1  one-cycle protocol error pulse

## Operation
- Command codes: 0x00 NOP, 0x01 SWRESET, 0x11 SLPOUT, 0x28 DISPOFF, 0x29 DISPON, 0x2A CASET, 0x2B PASET, 0x2C RAMWR.
- FSM states: IDLE, CASET_P, PASET_P, RAM_LO, RAM_HI.
- Any accepted byte with dcx=0 is a new command: aborts any partial CASET/PASET (no update) and discards a pending RAM_LO byte, then decodes.
- NOP: no effect, go to IDLE. DISPON/DISPOFF: set/clear disp_on. SLPOUT: clear sleeping, start wait. SWRESET: window to full screen, disp_on=0, sleeping=1, start wait. All of these go to IDLE.
- CASET/PASET: 4 data bytes, order start[15:8], start[7:0], end[15:8], end[7:0]; param index 0..3. Commits on the 4th byte only if start<=end and end<limit (WIDTH or HEIGHT); otherwise cmd_err is pulsed and the old window is kept. State returns to IDLE after the 4th byte.
- RAMWR: pointer set to (SC, SP); state RAM_LO. Data bytes alternate: the first is colour[7:0], the second is colour[15:8] and emits a pixel at the current pointer.
- Pointer advance after each pixel: x++; x past EC wraps to SC with y++; y past EP wraps to SP. The window is inclusive at both ends.
- Error conditions: a data byte in IDLE, an unknown command code, or any byte during the wait period. Each pulses cmd_err for one cycle and the byte is dropped; the state is unchanged except that an unknown command goes to IDLE.

## Timing
- Reset values: px_valid=0, px_x=0, px_y=0, px_color=0, disp_on=0, sleeping=1, cmd_err=0, state IDLE, window SC=0, EC=WIDTH-1, SP=0, EP=HEIGHT-1, wait counter 0.
- All outputs are registered. px_valid and cmd_err are asserted in the cycle after the causing byte's wr_en cycle. disp_on and sleeping update in the same registered way.
- Wait period: the counter loads WAIT_CYCLES on the edge that accepts SWRESET or SLPOUT, then decrements each cycle. Bytes are accepted only when the counter is 0, i.e. from cycle N+WAIT_CYCLES+1 onward, where N is the command's cycle.
- The window commit is visible to a RAMWR arriving in the very next cycle.
- Back-to-back wr_en is supported at full rate, giving one pixel every 2 cycles.
- Reset asserted mid-operation returns everything to reset values immediately. Partial parameters and pending bytes are lost.

## Structure
- Package lcd_pkg holds:
  - command code localparams;
  - the state enum lcd_dec_state_t;
  - the RGB565 typedef.
- Sub-module lcd_addr_ptr holds the window registers and the x/y pointer, with load and advance controls and wrap logic. The FSM stays in lcd_cmd_decoder.

## Test plan
- Reset, then DISPON with SLPOUT placed after it -> disp_on=1, sleeping=0; a byte sent 10 cycles after SLPOUT -> cmd_err, byte dropped.
- CASET 0,20,0,40; PASET 0,40,0,60; RAMWR; colour bytes 0x00,0xF8 repeated 21×21 times -> 441 px_valid with px_color=0xF800, x sweeping 20..40 and y 40..60. The 442nd pixel lands at (20,40).
- CASET 0,50,0,10 (start>end) -> cmd_err, window unchanged; next RAMWR pixel lands at the previous SC,SP.
- CASET cut after 2 bytes by DISPOFF -> window unchanged, disp_on=0, no cmd_err.
- RAMWR with one low byte, then NOP, then RAMWR with 0x1E,0x90 -> exactly one pixel 0x901E at (SC,SP).
- Data byte in IDLE, or command 0x55 -> one-cycle cmd_err; rst pulse mid-RAMWR -> all outputs return to reset values.
